// File: rtl/ps2_dir_decoder.sv
// PS/2 keyboard receiver that decodes WASD and arrow-key make/break codes into a
// held one-hot direction, and strobes out every good byte.
module ps2_dir_decoder #(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [3:0] dirMove,
  output logic [7:0] scan_code,
  output logic       code_valid,
  output logic       frame_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_e;

  logic          clk_s1_q, clk_s2_q, data_s1_q, data_s2_q;
  logic          filt_q;
  logic [FW-1:0] filt_cnt_q;
  logic          filt_flip, fe;

  state_e        state_q;
  logic [2:0]    bit_cnt_q;
  logic [TW-1:0] to_cnt_q;
  logic [7:0]    shift_q;
  logic          par_ok_q;
  logic [7:0]    scan_q;
  logic [3:0]    dir_q;
  logic          ext_q, brk_q;
  logic          code_valid_q, frame_err_q;

  logic [3:0]    key_oh;
  logic [3:0]    dir_d;
  logic          ext_d, brk_d;

  // Idle PS/2 lines float high, so the synchronizers come out of reset at 1.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clk_s1_q  <= 1'b1;
      clk_s2_q  <= 1'b1;
      data_s1_q <= 1'b1;
      data_s2_q <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments let every flop sample the old value, which is what makes this a two-stage chain.
      clk_s1_q  <= ps2_clk;
      clk_s2_q  <= clk_s1_q;
      data_s1_q <= ps2_data;
      data_s2_q <= data_s1_q;
    end
  end

  assign filt_flip = (clk_s2_q != filt_q) && (filt_cnt_q == FW'(FILTER_LEN - 1));
  assign fe        = filt_flip && filt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      filt_q     <= 1'b1;
      filt_cnt_q <= '0;
    end else if (clk_s2_q == filt_q) begin
      filt_cnt_q <= '0;
    end else if (filt_flip) begin
      filt_q     <= clk_s2_q;
      filt_cnt_q <= '0;
    end else begin
      filt_cnt_q <= filt_cnt_q + FW'(1);
    end
  end

  // Next direction and prefix flags if the byte in shift_q turns out to be good.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a variable unassigned (no latch).
    dir_d  = dir_q;
    ext_d  = ext_q;
    brk_d  = brk_q;
    key_oh = 4'b0000;
    if (shift_q == 8'hE0) begin
      ext_d = 1'b1;
    end else if (shift_q == 8'hF0) begin
      brk_d = 1'b1;
    end else begin
      case ({ext_q, shift_q})
        9'h01D:  key_oh = 4'b0001;
        9'h01B:  key_oh = 4'b0010;
        9'h01C:  key_oh = 4'b0100;
        9'h023:  key_oh = 4'b1000;
        9'h175:  key_oh = 4'b0001;
        9'h172:  key_oh = 4'b0010;
        9'h16B:  key_oh = 4'b0100;
        9'h174:  key_oh = 4'b1000;
        default: key_oh = 4'b0000;
      endcase
      if (key_oh != 4'b0000) begin
        if (!brk_q)              dir_d = key_oh;
        else if (dir_q == key_oh) dir_d = 4'b0000;
      end
      ext_d = 1'b0;
      brk_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      to_cnt_q     <= '0;
      shift_q      <= '0;
      par_ok_q     <= 1'b0;
      scan_q       <= '0;
      dir_q        <= '0;
      ext_q        <= 1'b0;
      brk_q        <= 1'b0;
      code_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      code_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      if (state_q != IDLE && !fe && to_cnt_q == TW'(TIMEOUT_CYC - 1)) begin
        frame_err_q <= 1'b1;
        state_q     <= IDLE;
        to_cnt_q    <= '0;
      end else begin
        to_cnt_q <= (state_q == IDLE || fe) ? '0 : to_cnt_q + TW'(1);
        if (fe) begin
          case (state_q)
            IDLE: begin
              // A high data line at a clock edge is a false start, not an error.
              if (!data_s2_q) begin
                state_q   <= DATA;
                bit_cnt_q <= '0;
              end
            end
            DATA: begin
              shift_q   <= {data_s2_q, shift_q[7:1]};
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) state_q <= PARITY;
            end
            PARITY: begin
              par_ok_q <= ^{shift_q, data_s2_q};
              state_q  <= STOP;
            end
            STOP: begin
              if (data_s2_q && par_ok_q) begin
                code_valid_q <= 1'b1;
                scan_q       <= shift_q;
                dir_q        <= dir_d;
                ext_q        <= ext_d;
                brk_q        <= brk_d;
              end else begin
                frame_err_q <= 1'b1;
              end
              state_q <= IDLE;
            end
          endcase
        end
      end
    end
  end

  assign dirMove    = dir_q;
  assign scan_code  = scan_q;
  assign code_valid = code_valid_q;
  assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_ps2_dir_decoder.sv
// Scoreboard bench for ps2_dir_decoder: drives PS/2 frames, predicts each strobe
// with a small key model and compares outputs on the falling clock edge.
module tb_ps2_dir_decoder;

  localparam int FILTER_LEN  = 8;
  localparam int TIMEOUT_CYC = 2000;
  localparam int HALF        = 20;

  logic       clk = 1'b0;
  logic       reset;
  logic       ps2_clk;
  logic       ps2_data;
  logic [3:0] dirMove;
  logic [7:0] scan_code;
  logic       code_valid;
  logic       frame_err;

  typedef struct {
    bit         err;
    logic [7:0] code;
    logic [3:0] dir;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_errors = 0;
  int onehot_viol = 0;
  int overlap_viol = 0;
  int glitch_viol = 0;

  logic [3:0] m_dir;
  logic [7:0] m_scan;
  logic       m_ext, m_brk;

  ps2_dir_decoder #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk        (clk),
    .reset      (reset),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .dirMove    (dirMove),
    .scan_code  (scan_code),
    .code_valid (code_valid),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_dir  = 4'b0000;
    m_scan = 8'h00;
    m_ext  = 1'b0;
    m_brk  = 1'b0;
  endtask

  task automatic model_byte(input logic [7:0] b);
    logic [3:0] oh;
    m_scan = b;
    if (b == 8'hE0) m_ext = 1'b1;
    else if (b == 8'hF0) m_brk = 1'b1;
    else begin
      oh = 4'b0000;
      if (!m_ext) begin
        if (b == 8'h1D) oh = 4'b0001;
        if (b == 8'h1B) oh = 4'b0010;
        if (b == 8'h1C) oh = 4'b0100;
        if (b == 8'h23) oh = 4'b1000;
      end else begin
        if (b == 8'h75) oh = 4'b0001;
        if (b == 8'h72) oh = 4'b0010;
        if (b == 8'h6B) oh = 4'b0100;
        if (b == 8'h74) oh = 4'b1000;
      end
      if (oh != 4'b0000) begin
        if (!m_brk) m_dir = oh;
        else if (m_dir == oh) m_dir = 4'b0000;
      end
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
  endtask

  task automatic ps2_bit(input logic b);
    ps2_data = b;
    repeat (HALF) @(posedge clk);
    ps2_clk = 1'b0;
    repeat (HALF) @(posedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit flip_par = 0, input logic stop = 1'b1);
    exp_t e;
    logic par;
    par = ~(^b) ^ flip_par;
    if (flip_par || !stop) begin
      e.err = 1; e.code = m_scan; e.dir = m_dir;
    end else begin
      model_byte(b);
      e.err = 0; e.code = b; e.dir = m_dir;
    end
    sb.push_back(e);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(par);
    ps2_bit(stop);
    ps2_data = 1'b1;
    repeat (2 * HALF) @(posedge clk);
  endtask

  // Output monitor: pops the scoreboard on every strobe and tracks invariants.
  initial begin
    logic [3:0] prev_dir;
    exp_t e;
    prev_dir = 4'b0000;
    forever begin
      @(negedge clk);
      if (!(dirMove inside {4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000})) onehot_viol++;
      if (code_valid && frame_err) overlap_viol++;
      if (reset === 1'b1 && !code_valid && dirMove !== prev_dir) glitch_viol++;
      prev_dir = dirMove;
      if (code_valid || frame_err) begin
        if (sb.size() == 0) begin
          check("unexpected_strobe_queue_size", 32'(sb.size()), 1);
        end else begin
          e = sb.pop_front();
          check("strobe_is_err", 32'(frame_err), 32'(e.err));
          check("strobe_is_valid", 32'(code_valid), 32'(!e.err));
          check("scan_code", 32'(scan_code), 32'(e.code));
          check("dirMove_at_strobe", 32'(dirMove), 32'(e.dir));
        end
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset    = 1'b0;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    model_reset();
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("rst_dirMove", 32'(dirMove), 0);
    check("rst_scan_code", 32'(scan_code), 0);
    check("rst_code_valid", 32'(code_valid), 0);
    check("rst_frame_err", 32'(frame_err), 0);
    reset = 1'b1;
    repeat (4 * HALF) @(posedge clk);

    // Basic make/break, with a typematic repeat of the make code.
    send_frame(8'h1D);
    check("up_make", 32'(dirMove), 32'(4'b0001));
    send_frame(8'h1D);
    send_frame(8'hF0);
    send_frame(8'h1D);
    check("up_break", 32'(dirMove), 32'(4'b0000));

    // Extended arrows; break of a non-held key leaves the held one alone.
    send_frame(8'hE0); send_frame(8'h74);
    check("right_arrow", 32'(dirMove), 32'(4'b1000));
    send_frame(8'h1D);
    check("last_press_wins", 32'(dirMove), 32'(4'b0001));
    send_frame(8'hE0); send_frame(8'hF0); send_frame(8'h74);
    check("break_other_key", 32'(dirMove), 32'(4'b0001));
    send_frame(8'hF0); send_frame(8'h1D);
    check("break_held_key", 32'(dirMove), 32'(4'b0000));

    // Extended prefix with a non-arrow code: unmapped.
    send_frame(8'hE0); send_frame(8'h1D);
    check("ext_unmapped", 32'(dirMove), 32'(4'b0000));

    // Parity and stop errors must not disturb the held direction.
    send_frame(8'h23);
    send_frame(8'h1B, 1'b1, 1'b1);
    check("bad_parity_dir", 32'(dirMove), 32'(4'b1000));
    send_frame(8'h1B, 1'b0, 1'b0);
    check("bad_stop_dir", 32'(dirMove), 32'(4'b1000));

    // Truncated frame: start bit plus four data bits, then silence.
    begin
      exp_t e;
      e.err = 1; e.code = m_scan; e.dir = m_dir;
      sb.push_back(e);
      ps2_bit(1'b0);
      for (int i = 0; i < 4; i++) ps2_bit(1'b1);
      ps2_data = 1'b1;
      repeat (TIMEOUT_CYC + 10) @(posedge clk);
      check("timeout_strobe_seen", 32'(sb.size()), 0);
    end
    send_frame(8'h1C);
    check("after_timeout", 32'(dirMove), 32'(4'b0100));

    // Short low glitch on the clock, with data low so a false edge would start a frame.
    ps2_data = 1'b0;
    repeat (HALF) @(posedge clk);
    ps2_clk = 1'b0;
    repeat (3) @(posedge clk);
    ps2_clk = 1'b1;
    repeat (HALF) @(posedge clk);
    ps2_data = 1'b1;
    repeat (2 * HALF) @(posedge clk);
    check("glitch_no_effect", 32'(dirMove), 32'(4'b0100));
    send_frame(8'h23);
    check("after_glitch", 32'(dirMove), 32'(4'b1000));

    // Reset in the middle of the fifth data bit of a frame.
    send_frame(8'hE0); send_frame(8'h75);
    check("up_arrow", 32'(dirMove), 32'(4'b0001));
    begin
      logic [7:0] b;
      b = 8'h72;
      ps2_bit(1'b0);
      for (int i = 0; i < 4; i++) ps2_bit(b[i]);
      ps2_data = b[4];
      repeat (HALF / 2) @(posedge clk);
      #2 reset = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("midrst_dirMove", 32'(dirMove), 0);
      check("midrst_scan_code", 32'(scan_code), 0);
      check("midrst_code_valid", 32'(code_valid), 0);
      check("midrst_frame_err", 32'(frame_err), 0);
      model_reset();
      reset = 1'b1;
      ps2_data = 1'b1;
      repeat (4 * HALF) @(posedge clk);
    end
    send_frame(8'hE0); send_frame(8'h72);
    check("after_midrst", 32'(dirMove), 32'(4'b0010));

    repeat (TIMEOUT_CYC + 10) @(posedge clk);
    check("scoreboard_drained", 32'(sb.size()), 0);
    check("onehot_violations", 32'(onehot_viol), 0);
    check("valid_err_overlap", 32'(overlap_viol), 0);
    check("dir_change_without_strobe", 32'(glitch_viol), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ps2_dir_decoder.md
Name: ps2_dir_decoder

Overview:
- Receives PS/2 keyboard frames and decodes make and break scan codes for WASD and the arrow keys.
- Drives the one-hot `dirMove` bus consumed by the game core: 0001 up, 0010 down, 0100 left, 1000 right, 0000 no move.
- `dirMove` is level-held while the key is down; the game core samples it once per frame on `vs`.
- Also exports every good byte with a strobe, for debug and future menu use.

Parameters:
- FILTER_LEN, 8: consecutive identical synchronized samples required before the filtered `ps2_clk` level changes.
- TIMEOUT_CYC, 50000: clk cycles allowed between filtered `ps2_clk` falling edges inside a frame (2 ms at 25 MHz).

Ports:
- clk  in  1  system/pixel clock; all logic on posedge.
- reset  in  1  asynchronous, active-low reset.
- ps2_clk  in  1  raw PS/2 clock from the pin; asynchronous.
- ps2_data  in  1  raw PS/2 data from the pin; asynchronous.
- dirMove  out  4  one-hot held direction; 0000 when no direction key is held.
- scan_code  out  8  last good received byte.
- code_valid  out  1  one-cycle strobe; `scan_code` is updated in the same cycle.
- frame_err  out  1  one-cycle strobe on a parity, stop-bit or timeout error.

Behaviour:
- Reset, applied asynchronously while `reset`=0:
  - `dirMove`=0000, `scan_code`=00, `code_valid`=0, `frame_err`=0.
  - FSM in IDLE; ext/brk flags cleared; bit counter, timeout counter and filter counter at 0.
  - Filtered `ps2_clk` level = 1.
- Input conditioning:
  - 2-FF synchronizer on each of `ps2_clk` and `ps2_data`.
  - Filter: the filtered clock changes level only after FILTER_LEN consecutive samples at the new level. The counter resets whenever a sample equals the current filtered level.
  - A falling edge event (fe) is a 1-cycle pulse when the filtered level goes 1->0.
  - Data is sampled from synchronized `ps2_data` in the fe cycle.
- Frame FSM, advancing only on fe:
  - IDLE: data=0 -> DATA with bit count 0. data=1 is treated as a false start; stay IDLE with no error.
  - DATA: shift bits in LSB first. After the 8th bit -> PARITY.
  - PARITY: capture the bit. Parity is good when the ones count of the 8 data bits plus the parity bit is odd. Go to STOP.
  - STOP: requires data=1 and good parity. On success, in the next cycle `code_valid`=1 and `scan_code`=byte, and byte decode runs in that same cycle. On failure, `frame_err`=1 for one cycle and the byte is discarded. In both cases -> IDLE.
- Timeout:
  - In any state other than IDLE, the timeout counter increments every clk and clears on fe.
  - Reaching TIMEOUT_CYC -> `frame_err` pulse, FSM to IDLE, partial byte discarded, flags unchanged.
- Byte decode, on each good byte:
  - E0 -> set ext.
  - F0 -> set brk.
  - Any other byte:
    - Lookup with ext=0: 1D up, 1B down, 1C left, 23 right.
    - Lookup with ext=1: 75 up, 72 down, 6B left, 74 right.
    - Make (brk=0) of a mapped key: `dirMove` <= that one-hot. The last pressed key wins, replacing any held direction.
    - Break (brk=1) of a mapped key: `dirMove` <= 0000 only if it equals that key's one-hot; otherwise unchanged.
    - Unmapped codes, e.g. 1D with ext=1: no change to `dirMove`.
    - Clear ext and brk after any non-prefix byte.
- `dirMove` is always 0000 or exactly one bit set; it never glitches between updates.
- `code_valid` and `frame_err` never assert in the same cycle.
- Typematic repeat (repeated make codes) re-writes the same value; no visible change.
- Reset mid-frame: everything returns to reset values immediately. The frame in flight is lost; the next start bit begins a fresh frame.

Test Plan:
- Frame 1D (good parity) -> `code_valid` pulse, `scan_code`=1D, `dirMove`=0001. Then frames F0, 1D -> `dirMove`=0000 after the second byte.
- E0, 74 -> `dirMove`=1000. Then 1D -> 0001. Then E0, F0, 74 -> stays 0001. Then F0, 1D -> 0000.
- Frame 1B with inverted parity -> `frame_err` 1 cycle, no `code_valid`, `dirMove` unchanged. Frame 1B with stop=0 -> same result.
- Start bit plus 4 data bits, then idle for TIMEOUT_CYC+10 cycles -> single `frame_err`, FSM back in IDLE. A following good frame 1C -> `dirMove`=0100.
- 3-cycle low glitch on `ps2_clk` (below FILTER_LEN) -> no fe, state unchanged. A full frame 23 afterwards -> `dirMove`=1000.
- Hold 75 with ext set, pulse `reset` low during the 5th data bit of the next frame -> all outputs 0. A following E0, 72 -> `dirMove`=0010.
